// File: rtl/pipe_slot_scheduler.sv
// Central slot arbiter for the overlapped multicycle core: tracks in-flight slots and their
// age order, grants memory/ALU/fetch, resolves redirects with younger-slot flush and a fetch shadow.
module pipe_slot_scheduler #(
  parameter int NUM_SLOTS     = 5,
  parameter int SHADOW_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SLOTS-1:0]     slot_fetch_req,
  input  logic [NUM_SLOTS-1:0]     slot_dmem_req,
  input  logic [NUM_SLOTS-1:0]     slot_alu_req,
  input  logic [NUM_SLOTS-1:0]     slot_redirect,
  input  logic [2*NUM_SLOTS-1:0]   slot_redirect_src,
  output logic [NUM_SLOTS-1:0]     fetch_grant,
  output logic [NUM_SLOTS-1:0]     dmem_grant,
  output logic [NUM_SLOTS-1:0]     alu_grant,
  output logic [NUM_SLOTS-1:0]     stall,
  output logic [NUM_SLOTS-1:0]     flush,
  output logic                     pc_write,
  output logic [1:0]               pc_src,
  output logic [NUM_SLOTS-1:0]     busy,
  output logic                     shadow
);

  // older[i][j] = 1 means slot j is older than slot i
  typedef logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age_t;

  age_t                 older;
  age_t                 older_nxt;
  logic [2:0]           shadow_cnt;
  logic [2:0]           shadow_nxt;
  logic [NUM_SLOTS-1:0] busy_nxt;
  logic [NUM_SLOTS-1:0] redir_req;
  logic [NUM_SLOTS-1:0] redir_win;
  logic                 redir_any;
  logic [NUM_SLOTS-1:0] eligible;
  logic                 fetch_ok;
  logic [1:0]           win_src;
  logic [NUM_SLOTS-1:0] retire;
  logic [NUM_SLOTS-1:0] survivors;

  // Requester with no other requester older than itself; first match keeps the result one-hot.
  function automatic logic [NUM_SLOTS-1:0] pick_oldest(input logic [NUM_SLOTS-1:0] req,
                                                       input age_t age);
    logic [NUM_SLOTS-1:0] oh;
    logic                 found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && req[i] && ((age[i] & req) == '0)) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] pick_lowest(input logic [NUM_SLOTS-1:0] req);
    logic [NUM_SLOTS-1:0] oh;
    logic                 found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found && req[i]) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    redir_req = slot_redirect & busy;
    redir_win = pick_oldest(redir_req, older);
    redir_any = |redir_win;

    flush = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      flush[k] = busy[k] & (|(older[k] & redir_win));
    end

    eligible   = busy & ~flush;
    dmem_grant = pick_oldest(slot_dmem_req & eligible, older);
    alu_grant  = pick_oldest(slot_alu_req & eligible, older);

    // Data accesses hold the single memory port ahead of any new fetch.
    fetch_ok    = ~(|dmem_grant) & ~redir_any & (shadow_cnt == 3'd0);
    fetch_grant = fetch_ok ? pick_lowest(slot_fetch_req & ~busy) : '0;

    win_src = 2'b00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (redir_win[i]) win_src = win_src | slot_redirect_src[2*i +: 2];
    end

    pc_write = redir_any | (|fetch_grant);
    pc_src   = redir_any ? win_src : 2'b00;

    stall  = (eligible & ((slot_dmem_req & ~dmem_grant) | (slot_alu_req & ~alu_grant)))
           | (slot_fetch_req & ~fetch_grant);
    shadow = (shadow_cnt != 3'd0);
  end

  // A busy slot raising fetch_req is retiring its instruction this cycle.
  always_comb begin
    retire    = slot_fetch_req & busy;
    survivors = busy & ~flush & ~retire;
    busy_nxt  = survivors | fetch_grant;

    older_nxt = older;
    for (int r = 0; r < NUM_SLOTS; r++) begin
      for (int c = 0; c < NUM_SLOTS; c++) begin
        if (fetch_grant[c]) older_nxt[r][c] = 1'b0;
      end
      if (fetch_grant[r]) older_nxt[r] = survivors;
    end

    if (redir_any)                shadow_nxt = 3'(SHADOW_CYCLES);
    else if (shadow_cnt != 3'd0)  shadow_nxt = shadow_cnt - 3'd1;
    else                          shadow_nxt = shadow_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      older      <= '0;
      shadow_cnt <= 3'd0;
    end else begin
      busy       <= busy_nxt;
      older      <= older_nxt;
      shadow_cnt <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_slot_scheduler.sv
// Directed table-driven bench for pipe_slot_scheduler (NUM_SLOTS=5, SHADOW_CYCLES=2),
// plus a hand-written asynchronous reset sequence taken mid-operation.
module tb_pipe_slot_scheduler;
  localparam int N = 5;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] slot_fetch_req, slot_dmem_req, slot_alu_req, slot_redirect;
  logic [2*N-1:0] slot_redirect_src;
  logic [N-1:0] fetch_grant, dmem_grant, alu_grant, stall, flush, busy;
  logic         pc_write, shadow;
  logic [1:0]   pc_src;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0]   fr, dr, ar, rd;
    logic [2*N-1:0] src;
    logic [N-1:0]   fg, dg, ag, st, fl;
    logic           pw;
    logic [1:0]     ps;
    logic [N-1:0]   bz;
    logic           sh;
  } vec_t;

  vec_t tbl[$];

  pipe_slot_scheduler #(.NUM_SLOTS(N), .SHADOW_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .slot_fetch_req(slot_fetch_req), .slot_dmem_req(slot_dmem_req),
    .slot_alu_req(slot_alu_req), .slot_redirect(slot_redirect),
    .slot_redirect_src(slot_redirect_src),
    .fetch_grant(fetch_grant), .dmem_grant(dmem_grant), .alu_grant(alu_grant),
    .stall(stall), .flush(flush), .pc_write(pc_write), .pc_src(pc_src),
    .busy(busy), .shadow(shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [N-1:0] fr, dr, ar, rd, input logic [2*N-1:0] src,
                     input logic [N-1:0] fg, dg, ag, st, fl, input logic pw,
                     input logic [1:0] ps, input logic [N-1:0] bz, input logic sh);
    vec_t v;
    v.fr = fr; v.dr = dr; v.ar = ar; v.rd = rd; v.src = src;
    v.fg = fg; v.dg = dg; v.ag = ag; v.st = st; v.fl = fl;
    v.pw = pw; v.ps = ps; v.bz = bz; v.sh = sh;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [N-1:0] fr, dr, ar, rd, input logic [2*N-1:0] src);
    slot_fetch_req = fr; slot_dmem_req = dr; slot_alu_req = ar;
    slot_redirect = rd; slot_redirect_src = src;
  endtask

  initial begin
    rst_n = 1'b0;
    drive('0, '0, '0, '0, '0);

    //    fr        dr        ar        rd        src            fg        dg        ag        st        fl        pw    ps     busy      sh
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 2'b00, 5'b00000, 1'b0);
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00000, 1'b0);
    add(5'b00010, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00010, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00001, 1'b0);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00011, 1'b0);
    add(5'b00000, 5'b00000, 5'b00101, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00001, 5'b00100, 5'b00000, 1'b0, 2'b00, 5'b00111, 1'b0);
    add(5'b01000, 5'b00010, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00010, 5'b00000, 5'b01000, 5'b00000, 1'b0, 2'b00, 5'b00111, 1'b0);
    add(5'b01000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00111, 1'b0);
    // slot 1 (J) and slot 3 (JR) redirect together; slot 1 is older and wins
    add(5'b10000, 5'b00000, 5'b00000, 5'b01010, 10'h0C8, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b01100, 1'b1, 2'b10, 5'b01111, 1'b0);
    add(5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 2'b00, 5'b00011, 1'b1);
    add(5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00000, 1'b0, 2'b00, 5'b00011, 1'b1);
    add(5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00011, 1'b0);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00010, 10'h004, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 1'b1, 2'b01, 5'b10011, 1'b0);
    // second redirect inside the shadow reloads the counter
    add(5'b00100, 5'b00000, 5'b00000, 5'b00001, 10'h003, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00010, 1'b1, 2'b11, 5'b00011, 1'b1);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 1'b0, 2'b00, 5'b00001, 1'b1);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 1'b0, 2'b00, 5'b00001, 1'b1);
    add(5'b00100, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00001, 1'b0);
    // slot 0 retires, then refetches as the youngest slot
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b00001, 5'b00000, 1'b0, 2'b00, 5'b00101, 1'b0);
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00100, 1'b0);
    add(5'b00000, 5'b00101, 5'b00101, 5'b00000, 10'h000, 5'b00000, 5'b00100, 5'b00100, 5'b00001, 5'b00000, 1'b0, 2'b00, 5'b00101, 1'b0);
    add(5'b11010, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00010, 5'b00000, 5'b00000, 5'b11000, 5'b00000, 1'b1, 2'b00, 5'b00101, 1'b0);
    add(5'b01000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b00111, 1'b0);
    add(5'b10000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b1, 2'b00, 5'b01111, 1'b0);
    // all slots busy: no grant, every requester stalled
    add(5'b11111, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000, 1'b0, 2'b00, 5'b11111, 1'b0);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 10'h000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 1'b0, 2'b00, 5'b00000, 1'b0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].fr, tbl[i].dr, tbl[i].ar, tbl[i].rd, tbl[i].src);
      #1;
      chk("fetch_grant", i, 32'(fetch_grant), 32'(tbl[i].fg));
      chk("dmem_grant",  i, 32'(dmem_grant),  32'(tbl[i].dg));
      chk("alu_grant",   i, 32'(alu_grant),   32'(tbl[i].ag));
      chk("stall",       i, 32'(stall),       32'(tbl[i].st));
      chk("flush",       i, 32'(flush),       32'(tbl[i].fl));
      chk("pc_write",    i, 32'(pc_write),    32'(tbl[i].pw));
      chk("pc_src",      i, 32'(pc_src),      32'(tbl[i].ps));
      chk("busy",        i, 32'(busy),        32'(tbl[i].bz));
      chk("shadow",      i, 32'(shadow),      32'(tbl[i].sh));
    end

    // Asynchronous reset while four slots are busy and the shadow is loaded
    @(negedge clk); drive(5'b00001, '0, '0, '0, '0);
    @(negedge clk); drive(5'b00010, '0, '0, '0, '0);
    @(negedge clk); drive(5'b00100, '0, '0, '0, '0);
    @(negedge clk); drive(5'b01000, '0, '0, '0, '0);
    @(negedge clk); drive('0, '0, '0, 5'b01000, 10'h080);
    #1;
    chk("rst_seq_pc_src", 100, 32'(pc_src), 32'h2);
    chk("rst_seq_flush",  100, 32'(flush),  32'h0);
    @(negedge clk); drive('0, 5'b00100, 5'b00011, '0, '0);
    #1;
    chk("rst_seq_busy",   101, 32'(busy),       32'h0F);
    chk("rst_seq_shadow", 101, 32'(shadow),     32'h1);
    chk("rst_seq_dmem",   101, 32'(dmem_grant), 32'h04);
    chk("rst_seq_alu",    101, 32'(alu_grant),  32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy",   102, 32'(busy),        32'h0);
    chk("async_rst_shadow", 102, 32'(shadow),      32'h0);
    chk("async_rst_fetch",  102, 32'(fetch_grant), 32'h0);
    chk("async_rst_dmem",   102, 32'(dmem_grant),  32'h0);
    chk("async_rst_alu",    102, 32'(alu_grant),   32'h0);
    chk("async_rst_stall",  102, 32'(stall),       32'h0);
    chk("async_rst_pcw",    102, 32'(pc_write),    32'h0);
    @(negedge clk);
    drive('0, '0, '0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_busy", 103, 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_slot_scheduler.md
# pipe_slot_scheduler

Central arbiter for the overlapped multicycle MIPS core. It tracks up to NUM_SLOTS in-flight instructions, each owned by its own per-slot control FSM, and keeps an age order between them. Each cycle it grants the shared memory port (instruction fetch vs. data access) and the ALU, stalls the slots that lose, and resolves taken branches and jumps. On a redirect it flushes every younger slot, drives the PC update, and blocks new fetches for a programmable shadow window.

## Interface
Parameters:
- NUM_SLOTS, 5: number of per-slot FSMs (2..8).
- SHADOW_CYCLES, 2: cycles after a redirect during which no fetch is granted (0..7).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- slot_fetch_req  in  NUM_SLOTS  free slot asks to fetch a new instruction.
- slot_dmem_req  in  NUM_SLOTS  busy slot needs the memory port for a load or store this cycle.
- slot_alu_req  in  NUM_SLOTS  busy slot needs the ALU this cycle.
- slot_redirect  in  NUM_SLOTS  busy slot resolves a taken branch, J or JR this cycle.
- slot_redirect_src  in  2*NUM_SLOTS  per-slot PC_Src code; slot i uses bits [2i+1:2i]. Codes: 01 branch, 10 J, 11 JR.
- fetch_grant  out  NUM_SLOTS  one-hot or zero; the granted slot fetches now.
- dmem_grant  out  NUM_SLOTS  one-hot or zero; data access granted.
- alu_grant  out  NUM_SLOTS  one-hot or zero; ALU granted.
- stall  out  NUM_SLOTS  slot must hold its state this cycle.
- flush  out  NUM_SLOTS  slot must abandon its instruction and return to idle.
- pc_write  out  1  PC update enable.
- pc_src  out  2  PC source: 00 PC+4, 01 branch, 10 J, 11 JR.
- busy  out  NUM_SLOTS  slot holds a live instruction (registered).
- shadow  out  1  redirect shadow active (shadow counter non-zero).

## Operation
State:
- busy[N]: one bit per slot.
- Age matrix older[i][j]: 1 means slot j is older than slot i.
- Shadow counter: 3 bits.

All grant and flush outputs are combinational from the inputs and the registered state.

Redirect:
- Only redirects from busy slots count. If several are asserted, the oldest one wins: the slot i with no other redirecting busy slot j where older[i][j] = 1.
- flush[k] = busy[k] & older[k][win] for every slot k. The winning slot itself is not flushed.
- pc_write = 1 and pc_src = the winner's code.
- Redirects from flushed (younger) slots are ignored.
- The shadow counter loads SHADOW_CYCLES. A redirect arriving while the shadow is active reloads the counter.

Data memory and ALU arbitration:
- Eligible requesters are busy and not flushed.
- Each resource goes to the oldest eligible requester.

Fetch:
- A fetch is granted only when all of these hold: no dmem_grant this cycle, no redirect this cycle, shadow counter = 0, and at least one requesting slot is not busy.
- The grant goes to the lowest-index requesting non-busy slot.
- A fetch grant forces pc_write = 1 and pc_src = 00.
- Data accesses always beat fetches, because the data instruction is older.

Stall:
- stall[i] = (dmem_req & ~dmem_grant) | (alu_req & ~alu_grant) | (fetch_req & ~fetch_grant), with the dmem and alu terms masked by busy and ~flush.

Edge update, in priority order:
1. Flushed slots clear busy.
2. Slots with done (slot_alu_req/dmem not required) clear busy. There is no done input: a slot retires by deasserting busy via flush-equivalent. Retirement is signalled by slot_fetch_req asserted from a busy slot, which clears busy that cycle; it may be re-granted from the next cycle.
3. The fetch-granted slot sets busy. Row older[g][*] = current busy minus retiring/flushed slots. Column older[*][g] = 0.

Shadow counter: decrements by 1 per cycle while non-zero.

Reset:
- busy, older and the shadow counter all clear.
- With inputs at zero, every output is 0 (pc_src = 00).

## Timing
- Grant, flush, stall and the PC controls: 0-cycle latency, same cycle as the request.
- busy and age: visible the cycle after the grant.
- Redirect in cycle t: fetch is blocked in cycles t through t+SHADOW_CYCLES. The first possible fetch_grant is at t+SHADOW_CYCLES+1.
- SHADOW_CYCLES = 0: fetch is blocked only in the redirect cycle itself.
- All slots busy: fetch_req is held off with stall = 1 and no grant.
- Asynchronous reset mid-operation: all state clears immediately, and the outputs follow combinationally.

## Test plan
- Reset, then slot 0 requests fetch → fetch_grant = 00001, pc_write = 1, pc_src = 00; next cycle busy = 00001.
- Fetch into slots 0, 1, 2 in order; slots 2 and 0 raise alu_req together → alu_grant = 00001 and stall = 00100.
- Slot 1 busy requests dmem while slot 3 requests fetch → dmem_grant = 00010, fetch_grant = 0, stall[3] = 1.
- Slots 0–3 fetched in order; slot 1 redirects with src 10 while slot 3 also redirects with src 11 → pc_src = 10, flush = 01100; fetch is refused for 2 cycles, then the grant returns.
- Redirect during an active shadow → counter reloads; fetch is blocked for 3 cycles counted from the second redirect.
- Assert rst_n low while 4 slots are busy and shadow = 2 → busy = 0, shadow = 0, and all grants are 0 in the same cycle.
